// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses,
// mstatus field positions and the sequencer state encoding.
package trap_ctrl_pkg;

    localparam int unsigned CSR_ADDR_W = 12;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    // Trap entry walks T_*, mret walks R_*; the last state of each is the redirect.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        T_EPC   = 3'd1,
        T_CAUSE = 3'd2,
        T_TVAL  = 3'd3,
        T_STAT  = 3'd4,
        T_VEC   = 3'd5,
        R_STAT  = 3'd6,
        R_EPC   = 3'd7
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer. Owns the CSR write port while
// busy, performs one CSR access per cycle and ends with a PC redirect.
// Outputs are decoded combinationally from state, latched trap data and rd.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CAUSE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exc_req,
    input  logic [CAUSE_W-1:0]    exc_cause,
    input  logic [XLEN-1:0]       exc_pc,
    input  logic [XLEN-1:0]       exc_tval,
    input  logic                  mret,
    output logic                  busy,
    output logic                  csr_w,
    output logic [CSR_ADDR_W-1:0] csr,
    output logic [XLEN-1:0]       wd,
    input  logic [XLEN-1:0]       rd,
    output logic                  redirect,
    output logic [XLEN-1:0]       redirect_pc
);

    trap_state_e        state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [XLEN-1:0]    pc_q,    pc_d;
    logic [XLEN-1:0]    tval_q,  tval_d;

    // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous.
    function automatic logic [XLEN-1:0] mstatus_enter(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                                 = s;
        r[MSTATUS_MPIE]                   = s[MSTATUS_MIE];
        r[MSTATUS_MIE]                    = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
        return r;
    endfunction

    // mret: restore MIE from MPIE, set MPIE, stay in M-mode.
    function automatic logic [XLEN-1:0] mstatus_return(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                                 = s;
        r[MSTATUS_MIE]                    = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                   = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
        return r;
    endfunction

    // Target PCs are forced to 4-byte alignment (mtvec mode bits dropped).
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

    // State and latched trap data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
        end
    end

    // Next-state and CSR port decode; reset forces the IDLE output values.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        pc_d        = pc_q;
        tval_d      = tval_q;
        busy        = 1'b0;
        csr_w       = 1'b0;
        csr         = '0;
        wd          = '0;
        redirect    = 1'b0;
        redirect_pc = '0;

        unique case (state_q)
            IDLE: begin
                if (exc_req) begin
                    state_d = T_EPC;
                    cause_d = exc_cause;
                    pc_d    = exc_pc;
                    tval_d  = exc_tval;
                end else if (mret) begin
                    state_d = R_STAT;
                end
            end
            T_EPC: begin
                busy    = 1'b1;
                csr     = CSR_MEPC;
                csr_w   = 1'b1;
                wd      = pc_q;
                state_d = T_CAUSE;
            end
            T_CAUSE: begin
                busy    = 1'b1;
                csr     = CSR_MCAUSE;
                csr_w   = 1'b1;
                wd      = XLEN'(cause_q);
                state_d = T_TVAL;
            end
            T_TVAL: begin
                busy    = 1'b1;
                csr     = CSR_MTVAL;
                csr_w   = 1'b1;
                wd      = tval_q;
                state_d = T_STAT;
            end
            T_STAT: begin
                busy    = 1'b1;
                csr     = CSR_MSTATUS;
                csr_w   = 1'b1;
                wd      = mstatus_enter(rd);
                state_d = T_VEC;
            end
            T_VEC: begin
                busy        = 1'b1;
                csr         = CSR_MTVEC;
                redirect    = 1'b1;
                redirect_pc = align_pc(rd);
                state_d     = IDLE;
            end
            R_STAT: begin
                busy    = 1'b1;
                csr     = CSR_MSTATUS;
                csr_w   = 1'b1;
                wd      = mstatus_return(rd);
                state_d = R_EPC;
            end
            R_EPC: begin
                busy        = 1'b1;
                csr         = CSR_MEPC;
                redirect    = 1'b1;
                redirect_pc = align_pc(rd);
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort mid-sequence: no further writes or redirect once rst is seen.
        if (rst) begin
            busy        = 1'b0;
            csr_w       = 1'b0;
            csr         = '0;
            wd          = '0;
            redirect    = 1'b0;
            redirect_pc = '0;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a small CSR file model on its port.
module tb_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        exc_req;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret;
    logic        busy;
    logic        csr_w;
    logic [11:0] csr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    // CSR file model
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    int          redir_cnt = 0;

    trap_ctrl #(.XLEN(32), .CAUSE_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .exc_req     (exc_req),
        .exc_cause   (exc_cause),
        .exc_pc      (exc_pc),
        .exc_tval    (exc_tval),
        .mret        (mret),
        .busy        (busy),
        .csr_w       (csr_w),
        .csr         (csr),
        .wd          (wd),
        .rd          (rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational CSR read
    always_comb begin
        rd = 32'h0;
        case (csr)
            12'h300: rd = m_mstatus;
            12'h305: rd = m_mtvec;
            12'h341: rd = m_mepc;
            12'h342: rd = m_mcause;
            12'h343: rd = m_mtval;
            default: rd = 32'h0;
        endcase
    end

    // CSR write port (bench preset has priority) and redirect counter
    always @(posedge clk) begin
        if (pre_en) begin
            case (pre_addr)
                12'h300: m_mstatus <= pre_data;
                12'h305: m_mtvec   <= pre_data;
                12'h341: m_mepc    <= pre_data;
                12'h342: m_mcause  <= pre_data;
                12'h343: m_mtval   <= pre_data;
                default: ;
            endcase
        end else if (csr_w) begin
            case (csr)
                12'h300: m_mstatus <= wd;
                12'h305: m_mtvec   <= wd;
                12'h341: m_mepc    <= wd;
                12'h342: m_mcause  <= wd;
                12'h343: m_mtval   <= wd;
                default: ;
            endcase
        end
        if (redirect) redir_cnt <= redir_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},        32'(busy),        32'h0);
        chk({tag, ".csr_w"},       32'(csr_w),       32'h0);
        chk({tag, ".csr"},         32'(csr),         32'h0);
        chk({tag, ".wd"},          wd,               32'h0);
        chk({tag, ".redirect"},    32'(redirect),    32'h0);
        chk({tag, ".redirect_pc"}, redirect_pc,      32'h0);
    endtask

    task automatic chk_wr(input string tag, input logic [11:0] a, input logic [31:0] d);
        chk({tag, ".busy"},  32'(busy),  32'h1);
        chk({tag, ".csr_w"}, 32'(csr_w), 32'h1);
        chk({tag, ".csr"},   32'(csr),   32'(a));
        chk({tag, ".wd"},    wd,         d);
        chk({tag, ".redir"}, 32'(redirect), 32'h0);
    endtask

    task automatic chk_redir(input string tag, input logic [11:0] a, input logic [31:0] pc);
        chk({tag, ".busy"},  32'(busy),     32'h1);
        chk({tag, ".csr_w"}, 32'(csr_w),    32'h0);
        chk({tag, ".csr"},   32'(csr),      32'(a));
        chk({tag, ".redir"}, 32'(redirect), 32'h1);
        chk({tag, ".pc"},    redirect_pc,   pc);
    endtask

    task automatic preset(input logic [11:0] a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_en   = 1'b0;
    endtask

    initial begin
        int rc;
        rst       = 1'b1;
        exc_req   = 1'b0;
        exc_cause = 4'h0;
        exc_pc    = 32'h0;
        exc_tval  = 32'h0;
        mret      = 1'b0;
        pre_en    = 1'b0;
        pre_addr  = 12'h0;
        pre_data  = 32'h0;

        // Reset state
        step();
        chk_idle("rst_during");
        step();
        rst = 1'b0;
        step();
        chk_idle("rst_after");

        preset(12'h300, 32'h0000_0008);
        preset(12'h305, 32'h0000_0100);
        preset(12'h341, 32'h0);
        preset(12'h342, 32'h0);
        preset(12'h343, 32'h0);

        // Trap entry; inputs scrambled after accept to prove latching
        exc_req = 1'b1; exc_cause = 4'd2; exc_pc = 32'h18; exc_tval = 32'h0050_2073;
        chk("t1.idle_busy", 32'(busy), 32'h0);
        step();
        exc_req = 1'b0; exc_cause = 4'hF; exc_pc = 32'hFFFF_FFF0; exc_tval = 32'h1234_5678;
        chk_wr("t1.epc", 12'h341, 32'h18);
        step();
        chk_wr("t1.cause", 12'h342, 32'h2);
        step();
        chk_wr("t1.tval", 12'h343, 32'h0050_2073);
        step();
        chk_wr("t1.stat", 12'h300, 32'h0000_1880);
        step();
        chk_redir("t1.vec", 12'h305, 32'h100);
        step();
        chk_idle("t1.done");
        chk("t1.mepc",    m_mepc,    32'h18);
        chk("t1.mcause",  m_mcause,  32'h2);
        chk("t1.mtval",   m_mtval,   32'h0050_2073);
        chk("t1.mstatus", m_mstatus, 32'h0000_1880);

        // mret
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk_wr("r1.stat", 12'h300, 32'h0000_1888);
        step();
        chk_redir("r1.epc", 12'h341, 32'h18);
        step();
        chk_idle("r1.done");
        chk("r1.mstatus", m_mstatus, 32'h0000_1888);

        // exc_req and mret together: trap wins
        exc_req = 1'b1; mret = 1'b1; exc_cause = 4'd5; exc_pc = 32'h40; exc_tval = 32'h0;
        step();
        exc_req = 1'b0; mret = 1'b0;
        chk_wr("both.epc", 12'h341, 32'h40);
        step();
        chk_wr("both.cause", 12'h342, 32'h5);
        step();
        chk_wr("both.tval", 12'h343, 32'h0);
        step();
        chk_wr("both.stat", 12'h300, 32'h0000_1880);
        step();
        chk_redir("both.vec", 12'h305, 32'h100);
        step();
        chk_idle("both.done");
        chk("both.mepc",    m_mepc,    32'h40);
        chk("both.mstatus", m_mstatus, 32'h0000_1880);

        // Reset during T_CAUSE aborts the sequence
        rc = redir_cnt;
        exc_req = 1'b1; exc_cause = 4'd7; exc_pc = 32'h80; exc_tval = 32'h0000_DEAD;
        step();
        exc_req = 1'b0;
        chk_wr("abort.epc", 12'h341, 32'h80);
        step();
        rst = 1'b1;
        #1;
        chk_idle("abort.in_rst");
        step();
        rst = 1'b0;
        chk_idle("abort.next");
        step();
        step();
        step();
        chk_idle("abort.later");
        chk("abort.mtval",   m_mtval,   32'h0);
        chk("abort.mstatus", m_mstatus, 32'h0000_1880);
        chk("abort.mepc",    m_mepc,    32'h80);
        chk("abort.mcause",  m_mcause,  32'h5);
        chk("abort.redir_cnt", 32'(redir_cnt), 32'(rc));

        // mtvec low bits masked; MIE=0 gives MPIE=0
        preset(12'h305, 32'h0000_0103);
        exc_req = 1'b1; exc_cause = 4'd1; exc_pc = 32'h20; exc_tval = 32'h4;
        step();
        exc_req = 1'b0;
        chk_wr("vec.epc", 12'h341, 32'h20);
        step();
        chk_wr("vec.cause", 12'h342, 32'h1);
        step();
        chk_wr("vec.tval", 12'h343, 32'h4);
        step();
        chk_wr("vec.stat", 12'h300, 32'h0000_1800);
        step();
        chk_redir("vec.vec", 12'h305, 32'h100);
        step();
        chk_idle("vec.done");

        // Request pulsed while busy is ignored
        exc_req = 1'b1; exc_cause = 4'd3; exc_pc = 32'h60; exc_tval = 32'h8;
        step();
        exc_req = 1'b0;
        chk_wr("ign.epc", 12'h341, 32'h60);
        step();
        chk_wr("ign.cause", 12'h342, 32'h3);
        step();
        chk_wr("ign.tval", 12'h343, 32'h8);
        exc_req = 1'b1; exc_cause = 4'd9; exc_pc = 32'hA0; exc_tval = 32'h77;
        step();
        exc_req = 1'b0;
        chk_wr("ign.stat", 12'h300, 32'h0000_1800);
        step();
        chk_redir("ign.vec", 12'h305, 32'h100);
        step();
        chk_idle("ign.done");
        step();
        chk_idle("ign.stay");
        chk("ign.mcause", m_mcause, 32'h3);
        chk("ign.mepc",   m_mepc,   32'h60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width of all CSR and PC buses.
REQ-002 SHALL have parameter CAUSE_W, default 4, width of exception cause code.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock shared with CSR file.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 exc_req  input  1  exception request, sampled in IDLE only.
REQ-007 exc_cause  input  CAUSE_W  synchronous exception code.
REQ-008 exc_pc  input  XLEN  PC of faulting instruction.
REQ-009 exc_tval  input  XLEN  trap value (bad address or instruction word).
REQ-010 mret  input  1  mret retirement request, sampled in IDLE only.
REQ-011 busy  output  1  sequence in progress; selects this block's port in the CSR write mux, stalls the pipeline.
REQ-012 csr_w  output  1  CSR write enable.
REQ-013 csr  output  12  CSR address.
REQ-014 wd  output  XLEN  CSR write data.
REQ-015 rd  input  XLEN  CSR read data, combinational from csr.
REQ-016 redirect  output  1  one-cycle PC redirect strobe.
REQ-017 redirect_pc  output  XLEN  PC target, valid while redirect=1.

Function
REQ-018 States SHALL be IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_VEC, R_STAT, R_EPC.
REQ-019 IDLE: exc_req=1 -> T_EPC; else mret=1 -> R_STAT; exc_req has priority when both are high.
REQ-020 On leaving IDLE for T_EPC, exc_cause, exc_pc and exc_tval SHALL be latched; later input changes are ignored.
REQ-021 T_EPC: csr=0x341, wd=latched pc, csr_w=1.
REQ-022 T_CAUSE: csr=0x342, wd=zero-extended cause with bit 31=0, csr_w=1.
REQ-023 T_TVAL: csr=0x343, wd=latched tval, csr_w=1.
REQ-024 T_STAT: csr=0x300, csr_w=1, wd=rd with bit7 (MPIE)=rd[3], bit3 (MIE)=0, bits12:11 (MPP)=2'b11, other bits unchanged.
REQ-025 T_VEC: csr=0x305, csr_w=0, redirect=1, redirect_pc={rd[31:2],2'b00} (direct mode only); next state IDLE.
REQ-026 R_STAT: csr=0x300, csr_w=1, wd=rd with MIE=rd[7], MPIE=1, MPP=2'b11.
REQ-027 R_EPC: csr=0x341, csr_w=0, redirect=1, redirect_pc={rd[31:2],2'b00}; next state IDLE.
REQ-028 Latency: trap accept edge -> redirect in the 5th cycle; mret accept edge -> redirect in the 2nd cycle.
REQ-029 busy SHALL be 1 in every non-IDLE state, including the redirect cycle; 0 in IDLE.
REQ-030 Requests arriving while busy=1 SHALL be ignored; upstream holds them via the stall.
REQ-031 In IDLE, csr_w=0, csr=0, wd=0, redirect=0, redirect_pc=0.
REQ-032 All outputs SHALL be decoded from state, latched data and rd; no registered output delay.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE and clear latched cause, pc and tval to 0.
REQ-034 Reset mid-sequence SHALL abort with no further CSR writes and no redirect; writes already committed remain.
REQ-035 During and after reset, every output SHALL equal its IDLE value.

Structure
REQ-036 The shared package SHALL hold the CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343), mstatus bit positions (MIE 3, MPIE 7, MPP 12:11) and the state encoding.
REQ-037 No sub-module; the mstatus update SHALL be combinational logic inside trap_ctrl.

Verification
REQ-038 With mtvec=0x00000100 and mstatus=0x00000008, exc_req, cause=2, pc=0x18, tval=0x00502073 -> writes mepc=0x18, mcause=2, mtval=0x00502073, mstatus=0x00001880 in order; redirect_pc=0x100 in cycle 5.
REQ-039 With mepc=0x18 and mstatus=0x00001880, mret -> mstatus=0x00001888; redirect_pc=0x18 in cycle 2.
REQ-040 With exc_req and mret high in the same IDLE cycle -> trap sequence runs; mepc is written and mstatus is not restored.
REQ-041 With rst asserted in T_CAUSE -> mtval and mstatus are unchanged, redirect is never asserted, and busy=0 the next cycle.
REQ-042 With mtvec=0x00000103 -> redirect_pc=0x00000100.
REQ-043 With exc_req pulsed during T_TVAL -> no second sequence starts and busy drops after T_VEC.
